// File: rtl/lsu_rv32.sv
//==============================================================================
// Module      : lsu_rv32
// Description : RV32I load/store unit. Accepts one pipeline access at a time,
//               drives a single data-cache transaction with byte enables and
//               lane-replicated store data, and returns an extended load result
//               with a one-cycle completion pulse. Stalled cache accesses
//               time out with an error after WAIT_MAX consecutive stall cycles.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters:
//   WAIT_MAX       consecutive stalled WAIT cycles before a timeout error (>=1)
// Configuration macro:
//   LSU_MISALIGN_TRAP_EN  defined  : misaligned halfword/word accesses fault
//                         undefined: offending low address bits are ignored
// Ports:
//   iCLK, iRST     clock, synchronous active-high reset
//   iVALID/iLOAD   access request, 1 = load / 0 = store
//   iFUNCT3        RV32I width/sign code
//   iADDR/iWDATA   byte address, right-aligned store data
//   oREADY/oBUSY   idle (request accepted) / stall request
//   oDONE          one-cycle completion pulse, qualifies oRDATA and oERR
//   oMEM/oRW       cache transaction active, 1 = read / 0 = write
//   oMEMADDR       word index {2'b00, addr[31:2]}
//   oMEMWDATA/oBE  lane-replicated store data, byte enables
//   iMEMRDATA      cache read word
//   iSTALLD        cache not ready
//==============================================================================
`default_nettype none

module lsu_rv32 #(
    parameter int WAIT_MAX = 15
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iVALID,
    input  logic        iLOAD,
    input  logic [2:0]  iFUNCT3,
    input  logic [31:0] iADDR,
    input  logic [31:0] iWDATA,
    output logic        oREADY,
    output logic        oBUSY,
    output logic        oDONE,
    output logic [31:0] oRDATA,
    output logic        oERR,
    output logic        oMEM,
    output logic        oRW,
    output logic [31:0] oMEMADDR,
    output logic [31:0] oMEMWDATA,
    output logic [3:0]  oBE,
    input  logic [31:0] iMEMRDATA,
    input  logic        iSTALLD
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state_q;
    logic             load_q;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q, err_q, mem_q, rw_q;
    logic [31:0]      rdata_q, memaddr_q, memwdata_q;
    logic [3:0]       be_q;

    // Decode of the incoming request (only used on the IDLE accept edge).
    logic        legal_d;
    logic        misalign_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    always_comb begin
        legal_d = 1'b0;
        if (iLOAD) begin
            case (iFUNCT3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_d = 1'b1;
                default:                                legal_d = 1'b0;
            endcase
        end else begin
            case (iFUNCT3)
                3'b000, 3'b001, 3'b010: legal_d = 1'b1;
                default:                legal_d = 1'b0;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_d = ((iFUNCT3[1:0] == 2'b01) && iADDR[0]) ||
                        ((iFUNCT3[1:0] == 2'b10) && (iADDR[1:0] != 2'b00));
`else
    assign misalign_d = 1'b0;
`endif

    // Byte enables only qualify writes; reads fetch the whole word.
    always_comb begin
        be_d    = 4'b0000;
        wdata_d = iWDATA;
        case (iFUNCT3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << iADDR[1:0];
                wdata_d = {4{iWDATA[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {iADDR[1], 1'b0};
                wdata_d = {2{iWDATA[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = iWDATA;
            end
        endcase
        if (iLOAD) be_d = 4'b0000;
    end

    // Select the addressed lane and extend. Halfword selection uses only
    // addr[1], so an unaligned halfword (trap disabled) reads as aligned.
    function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                             input logic [1:0]  off,
                                             input logic [31:0] word);
        logic [31:0] bsh, hsh;
        bsh = word >> {off, 3'b000};
        hsh = word >> {off[1], 4'b0000};
        case (f3)
            3'b000:  load_ext = {{24{bsh[7]}}, bsh[7:0]};
            3'b001:  load_ext = {{16{hsh[15]}}, hsh[15:0]};
            3'b100:  load_ext = {24'h0, bsh[7:0]};
            3'b101:  load_ext = {16'h0, hsh[15:0]};
            default: load_ext = word;
        endcase
    endfunction

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= S_IDLE;
            load_q     <= 1'b0;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
            mem_q      <= 1'b0;
            rw_q       <= 1'b1;
            memaddr_q  <= 32'h0;
            memwdata_q <= 32'h0;
            be_q       <= 4'b0000;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (iVALID) begin
                        load_q   <= iLOAD;
                        funct3_q <= iFUNCT3;
                        off_q    <= iADDR[1:0];
                        if (!legal_d || misalign_d) begin
                            state_q <= S_RESP;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= 32'h0;
                        end else begin
                            state_q    <= S_ISSUE;
                            cnt_q      <= '0;
                            mem_q      <= 1'b1;
                            rw_q       <= iLOAD;
                            memaddr_q  <= {2'b00, iADDR[31:2]};
                            memwdata_q <= wdata_d;
                            be_q       <= be_d;
                        end
                    end
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (!iSTALLD || (cnt_q == CNT_LAST)) begin
                        state_q    <= S_RESP;
                        done_q     <= 1'b1;
                        err_q      <= iSTALLD;
                        rdata_q    <= (load_q && !iSTALLD) ?
                                      load_ext(funct3_q, off_q, iMEMRDATA) : 32'h0;
                        mem_q      <= 1'b0;
                        rw_q       <= 1'b1;
                        memaddr_q  <= 32'h0;
                        memwdata_q <= 32'h0;
                        be_q       <= 4'b0000;
                    end
                    if (iSTALLD) cnt_q <= cnt_q + 1'b1;
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    err_q   <= 1'b0;
                    rdata_q <= 32'h0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oREADY    = (state_q == S_IDLE);
    assign oBUSY     = ~oREADY;
    assign oDONE     = done_q;
    assign oERR      = err_q;
    assign oRDATA    = rdata_q;
    assign oMEM      = mem_q;
    assign oRW       = rw_q;
    assign oMEMADDR  = memaddr_q;
    assign oMEMWDATA = memwdata_q;
    assign oBE       = be_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_rv32.sv
//==============================================================================
// Module      : tb_lsu_rv32
// Description : Self-checking bench for lsu_rv32 (directed + random accesses
//               against a byte-lane arithmetic reference model).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_lsu_rv32;

    localparam int WAIT_MAX = 15;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iVALID;
    logic        iLOAD;
    logic [2:0]  iFUNCT3;
    logic [31:0] iADDR;
    logic [31:0] iWDATA;
    logic        oREADY, oBUSY, oDONE, oERR, oMEM, oRW;
    logic [31:0] oRDATA, oMEMADDR, oMEMWDATA;
    logic [3:0]  oBE;
    logic [31:0] iMEMRDATA;
    logic        iSTALLD;

    int npass = 0;
    int ntot  = 0;
    int nfail = 0;

    lsu_rv32 #(.WAIT_MAX(WAIT_MAX)) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iVALID    (iVALID),
        .iLOAD     (iLOAD),
        .iFUNCT3   (iFUNCT3),
        .iADDR     (iADDR),
        .iWDATA    (iWDATA),
        .oREADY    (oREADY),
        .oBUSY     (oBUSY),
        .oDONE     (oDONE),
        .oRDATA    (oRDATA),
        .oERR      (oERR),
        .oMEM      (oMEM),
        .oRW       (oRW),
        .oMEMADDR  (oMEMADDR),
        .oMEMWDATA (oMEMWDATA),
        .oBE       (oBE),
        .iMEMRDATA (iMEMRDATA),
        .iSTALLD   (iSTALLD)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_legal(input bit ld, input logic [2:0] f3);
        int codes_ld[$] = '{0, 1, 2, 4, 5};
        int codes_st[$] = '{0, 1, 2};
        int hits[$];
        if (ld) hits = codes_ld.find(x) with (x == int'(f3));
        else    hits = codes_st.find(x) with (x == int'(f3));
        return hits.size() != 0;
    endfunction

    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (a % m_size(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_lane(input logic [2:0] f3, input logic [31:0] a);
        int sz = m_size(f3);
        return int'(a % 4) / sz * sz;   // aligned down to the access size
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int v = ((1 << m_size(f3)) - 1) << m_lane(f3, a);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (m_size(f3))
            1:       return (d & 32'hFF) * 32'h01010101;
            2:       return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
        int sz = m_size(f3);
        logic [31:0] mask, v;
        if (sz == 4) return word;
        mask = (32'h1 << (8 * sz)) - 1;
        v = (word >> (8 * m_lane(f3, a))) & mask;
        if (!f3[2] && ((v >> (8 * sz - 1)) & 1)) v = v | ~mask;
        return v;
    endfunction

    // nstall < 0 means the cache never becomes ready (timeout expected).
    task automatic access(input string tag, input bit ld, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] word, input int nstall);
        bit fault, stall_prev, seen, unstable;
        int cyc, left;
        logic [31:0] s_addr, s_wd;
        logic [3:0]  s_be;
        logic        s_rw;
        fault = !m_legal(ld, f3) || m_misaligned(f3, a);
        chk({tag, ".ready"}, {oREADY, oBUSY}, 2'b10);
        iVALID = 1'b1; iLOAD = ld; iFUNCT3 = f3; iADDR = a; iWDATA = wd;
        iMEMRDATA = word;
        left = (nstall < 0) ? 1000 : nstall;
        iSTALLD = (left > 0);
        @(posedge iCLK); #1;
        iVALID = 1'b0;
        if (fault) begin
            chk({tag, ".err_resp"}, {oDONE, oERR, oMEM, oBUSY}, 4'b1101);
            chk({tag, ".err_rdata"}, oRDATA, 32'h0);
        end else begin
            chk({tag, ".mem"}, {oMEM, oRW, oBUSY, oDONE}, {1'b1, ld, 1'b1, 1'b0});
            chk({tag, ".memaddr"}, oMEMADDR, {2'b00, a[31:2]});
            chk({tag, ".be"}, oBE, ld ? 4'b0000 : m_be(f3, a));
            if (!ld) chk({tag, ".wdata"}, oMEMWDATA, m_wdata(f3, wd));
            s_addr = oMEMADDR; s_wd = oMEMWDATA; s_be = oBE; s_rw = oRW;
            cyc = 0; seen = 0; unstable = 0;
            while (!seen && cyc < 60) begin
                stall_prev = iSTALLD;
                @(posedge iCLK); #1;
                cyc++;
                if (cyc >= 2 && stall_prev) left--;
                iSTALLD = (left > 0);
                if (oDONE === 1'b1) seen = 1;
                else begin
                    if (oMEM !== 1'b1 || oMEMADDR !== s_addr || oMEMWDATA !== s_wd ||
                        oBE !== s_be || oRW !== s_rw) unstable = 1;
                    iVALID = 1'($urandom_range(0, 1));  // ignored while busy
                end
            end
            iVALID = 1'b0; iSTALLD = 1'b0;
            chk({tag, ".done_seen"}, 32'(seen), 32'd1);
            chk({tag, ".stable"}, 32'(unstable), 32'd0);
            if (nstall >= 0) chk({tag, ".latency"}, cyc, 2 + nstall);
            chk({tag, ".err"}, oERR, (nstall < 0) ? 1'b1 : 1'b0);
            chk({tag, ".rdata"}, oRDATA,
                (ld && nstall >= 0) ? m_load(f3, a, word) : 32'h0);
            chk({tag, ".mem_off"}, {oMEM, oBE}, 5'b0);
        end
        @(posedge iCLK); #1;
        chk({tag, ".post"}, {oDONE, oREADY, oMEM, oERR, oBE}, 8'b0100_0000);
    endtask

    initial begin
        int ndone;
        iRST = 1'b1; iVALID = 1'b0; iLOAD = 1'b0; iFUNCT3 = 3'b0;
        iADDR = 32'h0; iWDATA = 32'h0; iMEMRDATA = 32'h0; iSTALLD = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;
        chk("rst.flags", {oREADY, oBUSY, oDONE, oERR, oMEM, oRW}, 6'b100001);
        chk("rst.memaddr", oMEMADDR, 32'h0);
        chk("rst.memwdata", oMEMWDATA, 32'h0);
        chk("rst.be", oBE, 4'b0000);
        chk("rst.rdata", oRDATA, 32'h0);
        iRST = 1'b0;

        // directed cases
        access("sw",  1'b0, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        access("lb",  1'b1, 3'b000, 32'h13, 32'h0, 32'h80FF7F01, 0);
        access("lbu", 1'b1, 3'b100, 32'h13, 32'h0, 32'h80FF7F01, 0);
        access("sh",  1'b0, 3'b001, 32'h06, 32'h0000ABCD, 32'h0, 1);
        access("lw_to", 1'b1, 3'b010, 32'h20, 32'h0, 32'h12345678, -1);
        access("lh_mis", 1'b1, 3'b001, 32'h01, 32'h0, 32'hCAFE8001, 0);
        access("sw_mis", 1'b0, 3'b010, 32'h102, 32'h11223344, 32'h0, 0);
        access("ill_st", 1'b0, 3'b100, 32'h40, 32'h5, 32'h0, 0);
        access("ill_ld", 1'b1, 3'b011, 32'h40, 32'h0, 32'h0, 0);
        access("lhu", 1'b1, 3'b101, 32'h22, 32'h0, 32'h9ABC1234, 2);

        // reset while waiting on a stalled read
        iVALID = 1'b1; iLOAD = 1'b1; iFUNCT3 = 3'b010; iADDR = 32'h80; iSTALLD = 1'b1;
        @(posedge iCLK); #1;
        iVALID = 1'b0;
        @(posedge iCLK); #1;
        chk("abort.in_wait", {oMEM, oBUSY}, 2'b11);
        iRST = 1'b1;
        @(posedge iCLK); #1;
        iRST = 1'b0; iSTALLD = 1'b0;
        chk("abort.state", {oMEM, oREADY, oDONE, oBE}, 7'b0100000);
        ndone = 0;
        repeat (6) begin
            @(posedge iCLK); #1;
            if (oDONE === 1'b1) ndone++;
        end
        chk("abort.no_done", ndone, 0);

        // random accesses
        for (int i = 0; i < 40; i++) begin
            access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
